sample_vec_sequencer: RTL and testbench
=======================================

// Module: sample_vec_sequencer
// PURPOSE
//  Synthesisable stimulus stage directly upstream of the 3-in/2-out combinational sample block.
//  Walks vectors {a,b,c} = 0..NUM_VEC-1, holding each for DWELL clocks.
//  Captures the block's d/e responses at the end of each dwell into a response register.
//  Replaces hand-timed #10 stepping with a clocked, start/done-controlled sequence.
// PARAMETERS
//  NUM_VEC  4   number of vectors driven, 1..8; vector i drives {a,b,c} = i[2:0]
//  DWELL    10  clocks each vector is held, >=1
//  CNT_W    4   dwell counter width, must satisfy 2**CNT_W >= DWELL
// PORTS
//  clk      in   1          single clock, rising edge
//  rst_n    in   1          asynchronous, active-low reset
//  start    in   1          begin sequence; sampled only in IDLE
//  abort    in   1          terminate sequence; any state
//  a,b,c    out  1 each     stimulus to sample block; a = MSB of vector index
//  d_in     in   1          response d from sample block
//  e_in     in   1          response e from sample block
//  busy     out  1          high in DRIVE
//  done     out  1          one-cycle pulse after last capture
//  vec_idx  out  3          index of vector currently driven
//  resp     out  2*NUM_VEC  resp[2i+1:2i] = {d,e} captured for vector i
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0; resp cleared.
//  FSM states: IDLE, DRIVE, DONE.
//   IDLE -> DRIVE on start & !abort; on that edge vec_idx<=0, dwell_cnt<=0, resp<=0.
//   DRIVE: {a,b,c}=vec_idx; dwell_cnt++ each clk.
//    When dwell_cnt==DWELL-1: resp[2*vec_idx+:2]<={d_in,e_in}.
//    Then if vec_idx==NUM_VEC-1 -> DONE, else vec_idx++, dwell_cnt<=0.
//   DONE: done=1 for exactly one cycle, {a,b,c}=0 -> IDLE.
//  Latency: start at edge t -> busy and vector 0 visible after t.
//   Capture of vector i at edge t+(i+1)*DWELL.
//   done high in cycle after edge t+NUM_VEC*DWELL.
//  abort: highest priority; any state -> IDLE next edge; a,b,c,busy<=0, done not pulsed.
//   resp keeps captures already made.
//  start in DRIVE/DONE: ignored. start & abort in IDLE: stay IDLE.
//  DWELL==1: capture every clk, vector changes every clk.
//  NUM_VEC==1: single capture then DONE.
//  Outputs registered; d_in/e_in sampled synchronously; sample block path must meet one clk.
//  Async reset mid-sequence: immediate return to reset values; no done.
// CONFIGURATION
//  SAMPLE_SEQ_SIG_EN defined:
//   Adds output sig [7:0], cleared on start.
//   On each capture: sig <= {sig[6:0],sig[7]} ^ {6'b0,d_in,e_in}.
//   Value held after DONE/abort; 0 after reset.
//  SAMPLE_SEQ_SIG_EN undefined: no sig port, no signature logic; all other behaviour identical.
// STRUCTURE
//  Shared include sample_defs.vh: state encodings ST_IDLE=2'd0, ST_DRIVE=2'd1, ST_DONE=2'd2.
//   Also holds vector width localparam VEC_W=3.
//  One sub-module: sample_dwell_counter (clear, enable, CNT_W count, terminal flag at DWELL-1).
//  FSM, resp capture and optional signature stay in sample_vec_sequencer.
// TESTING (bench drives d_in/e_in; NUM_VEC=4, DWELL=10 unless noted)
//  1 Reset: rst_n=0 -> a,b,c,busy,done,vec_idx,resp all 0; hold after release with start=0.
//  2 Full run, d_in=b, e_in=c:
//     {a,b,c} steps 000,001,010,011 every 10 clks; resp=8'b11_10_01_00.
//     done pulse 41 clks after start edge.
//  3 Abort at clk 25 after start:
//     IDLE next edge, a,b,c=0, no done; resp[3:0] holds 2 captures, resp[7:4]=0.
//  4 start re-pulsed during DRIVE -> ignored, sequence/timing unchanged.
//     start&abort in IDLE -> stays IDLE.
//  5 DWELL=1, NUM_VEC=8: vec_idx 0..7 on consecutive clks; done on 9th clk; resp per stimulus.
//  6 rst_n low at clk 15 mid-run -> outputs 0 asynchronously; next start runs cleanly.
//     With SAMPLE_SEQ_SIG_EN, d_in=e_in=1 all run: sig=8'h03,8'h05,8'h09,8'h11.

Source files
------------

// File: rtl/sample_vec_sequencer_pkg.sv
// Shared encodings for the sample-block stimulus sequencer: FSM states, vector width
// and the signature rotate helper.
package sample_vec_sequencer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int VEC_W = 3;

  function automatic logic [7:0] sig_step(input logic [7:0] sig, input logic [1:0] de);
    return {sig[6:0], sig[7]} ^ {6'b000000, de};
  endfunction

endpackage

// File: rtl/sample_dwell_counter.sv
// Dwell counter: counts enabled clocks, wraps to zero after DWELL-1 and flags that
// terminal count combinationally from the registered value.
module sample_dwell_counter #(
  parameter int DWELL = 10,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign term_o = (cnt_q == CNT_W'(DWELL - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = term_o ? '0 : cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sample_vec_sequencer.sv
// Clocked stimulus sequencer for the 3-in/2-out sample block: walks {a,b,c} through
// 0..NUM_VEC-1 and captures {d,e} per vector. Define SAMPLE_SEQ_SIG_EN for the sig output.
module sample_vec_sequencer
  import sample_vec_sequencer_pkg::*;
#(
  parameter int NUM_VEC = 4,
  parameter int DWELL   = 10,
  parameter int CNT_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 a,
  output logic                 b,
  output logic                 c,
  input  logic                 d_in,
  input  logic                 e_in,
  output logic                 busy,
  output logic                 done,
  output logic [VEC_W-1:0]     vec_idx,
  output logic [2*NUM_VEC-1:0] resp
`ifdef SAMPLE_SEQ_SIG_EN
  ,
  output logic [7:0]           sig
`endif
);

  logic [1:0]           state_q, state_d;
  logic [VEC_W-1:0]     vec_q, vec_d;
  logic [VEC_W-1:0]     abc_q, abc_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*NUM_VEC-1:0] resp_q, resp_d;
  logic                 cnt_clr_s, cnt_en_s, term_s;
  logic                 start_acc_s, capture_s;

  sample_dwell_counter #(.DWELL(DWELL), .CNT_W(CNT_W)) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr_s),
    .en_i   (cnt_en_s),
    .term_o (term_s)
  );

  assign start_acc_s = (state_q == ST_IDLE) && start && !abort;
  assign capture_s   = (state_q == ST_DRIVE) && term_s && !abort;
  assign cnt_en_s    = (state_q == ST_DRIVE) && !abort;
  assign cnt_clr_s   = !cnt_en_s;

  // Abort overrides everything; otherwise step the IDLE/DRIVE/DONE sequence.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    abc_d   = abc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    resp_d  = resp_q;
    if (abort) begin
      state_d = ST_IDLE;
      vec_d   = '0;
      abc_d   = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_acc_s) begin
            state_d = ST_DRIVE;
            vec_d   = '0;
            abc_d   = '0;
            busy_d  = 1'b1;
            resp_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DRIVE: begin
          if (capture_s) begin
            for (int i = 0; i < NUM_VEC; i++) begin
              resp_d[2*i +: 2] = (vec_q == VEC_W'(i)) ? {d_in, e_in} : resp_q[2*i +: 2];
            end
            if (vec_q == VEC_W'(NUM_VEC - 1)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              vec_d   = '0;
              abc_d   = '0;
              busy_d  = 1'b0;
            end else begin
              vec_d = vec_q + VEC_W'(1);
              abc_d = vec_q + VEC_W'(1);
            end
          end else begin
            state_d = ST_DRIVE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          vec_d   = '0;
          abc_d   = '0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      abc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      abc_q   <= abc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      resp_q  <= resp_d;
    end
  end

  assign {a, b, c} = abc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign vec_idx   = vec_q;
  assign resp      = resp_q;

`ifdef SAMPLE_SEQ_SIG_EN
  logic [7:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (start_acc_s) begin
      sig_d = 8'h00;
    end else if (capture_s) begin
      sig_d = sig_step(sig_q, {d_in, e_in});
    end else begin
      sig_d = sig_q;
    end
  end

  // Signature register, held across DONE and abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 8'h00;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;
`endif

endmodule

// File: tb/tb_sample_vec_sequencer.sv
// Directed bench for sample_vec_sequencer: NUM_VEC=4/DWELL=10 and NUM_VEC=8/DWELL=1
// instances, with the sample block modelled by simple assigns.
module tb_sample_vec_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, d_ones = 1'b0;
  logic a, b, c, d_in, e_in, busy, done;
  logic [2:0] vec_idx;
  logic [7:0] resp;
  logic start1 = 1'b0, abort1 = 1'b0;
  logic a1, b1, c1, d1, e1, busy1, done1;
  logic [2:0] vec_idx1;
  logic [15:0] resp1;
`ifdef SAMPLE_SEQ_SIG_EN
  logic [7:0] sig, sig1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign d_in = d_ones ? 1'b1 : b;
  assign e_in = d_ones ? 1'b1 : c;
  assign d1   = a1;
  assign e1   = b1 ^ c1;

  sample_vec_sequencer #(.NUM_VEC(4), .DWELL(10), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a(a), .b(b), .c(c), .d_in(d_in), .e_in(e_in),
    .busy(busy), .done(done), .vec_idx(vec_idx), .resp(resp)
`ifdef SAMPLE_SEQ_SIG_EN
    , .sig(sig)
`endif
  );

  sample_vec_sequencer #(.NUM_VEC(8), .DWELL(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .a(a1), .b(b1), .c(c1), .d_in(d1), .e_in(e1),
    .busy(busy1), .done(done1), .vec_idx(vec_idx1), .resp(resp1)
`ifdef SAMPLE_SEQ_SIG_EN
    , .sig(sig1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run4(input int restart_at, input int abort_at, input logic ones);
    logic [7:0] rexp;
    logic [7:0] sexp;
    logic [1:0] de;
    logic [2:0] v3;
    bit live;
    int vi;
    rexp = 8'h00;
    sexp = 8'h00;
    live = 1'b1;
    d_ones = ones;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("abc_after_start", 32'({a, b, c}), 32'd0);
    for (int k = 1; k <= 45; k++) begin
      start = (k == restart_at);
      abort = (k == abort_at);
      tick();
      start = 1'b0;
      abort = 1'b0;
      if (k == abort_at) live = 1'b0;
      if (live && k <= 40 && (k % 10) == 0) begin
        vi = k / 10 - 1;
        v3 = 3'(vi);
        de = ones ? 2'b11 : {v3[1], v3[0]};
        rexp[2*vi +: 2] = de;
        sexp = {sexp[6:0], sexp[7]} ^ {6'b000000, de};
      end
      if (live && k < 40) begin
        chk("abc_drive", 32'({a, b, c}), 32'(k / 10));
        chk("vec_idx_drive", 32'(vec_idx), 32'(k / 10));
        chk("busy_drive", 32'(busy), 32'd1);
        chk("done_drive", 32'(done), 32'd0);
      end else if (live && k == 40) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        chk("abc_done", 32'({a, b, c}), 32'd0);
      end else begin
        chk("done_idle", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("abc_idle", 32'({a, b, c}), 32'd0);
      end
      chk("resp_track", 32'(resp), 32'(rexp));
`ifdef SAMPLE_SEQ_SIG_EN
      chk("sig_track", 32'(sig), 32'(sexp));
`endif
    end
    if (abort_at == 0) begin
      chk("resp_final", 32'(resp), ones ? 32'h0000_00FF : 32'h0000_00E4);
`ifdef SAMPLE_SEQ_SIG_EN
      if (ones) chk("sig_final", 32'(sig), 32'h0000_0011);
`endif
    end else begin
      chk("resp_abort_low", 32'(resp[3:0]), 32'h4);
      chk("resp_abort_high", 32'(resp[7:4]), 32'h0);
    end
  endtask

  initial begin
    // Reset values, then idle with start low.
    #3;
    chk("rst_abc", 32'({a, b, c}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_vec_idx", 32'(vec_idx), 32'd0);
    chk("rst_resp", 32'(resp), 32'd0);
    chk("rst_resp1", 32'(resp1), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_abc", 32'({a, b, c}), 32'd0);

    // Full run with d=b, e=c.
    run4(0, 0, 1'b0);
    // Start re-pulsed mid-drive is ignored.
    run4(15, 0, 1'b0);

    // start and abort together in IDLE.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd0);
    tick();
    chk("start_abort_busy2", 32'(busy), 32'd0);
    chk("start_abort_done", 32'(done), 32'd0);

    // Abort at clock 25 keeps the two captures already made.
    run4(0, 25, 1'b0);

    // DWELL=1, NUM_VEC=8.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("d1_vec0", 32'(vec_idx1), 32'd0);
    chk("d1_busy", 32'(busy1), 32'd1);
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k < 8) begin
        chk("d1_vec_idx", 32'(vec_idx1), 32'(k));
        chk("d1_abc", 32'({a1, b1, c1}), 32'(k));
        chk("d1_done_low", 32'(done1), 32'd0);
      end else if (k == 8) begin
        chk("d1_done", 32'(done1), 32'd1);
        chk("d1_resp", 32'(resp1), 32'h0000_BE14);
      end else begin
        chk("d1_done_after", 32'(done1), 32'd0);
      end
    end

    // Asynchronous reset mid-run, then a clean rerun with d=e=1.
    d_ones = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_abc", 32'({a, b, c}), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_vec_idx", 32'(vec_idx), 32'd0);
    chk("arst_resp", 32'(resp), 32'd0);
`ifdef SAMPLE_SEQ_SIG_EN
    chk("arst_sig", 32'(sig), 32'd0);
`endif
    tick();
    chk("arst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();
    run4(0, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
